// File: rtl/psum_arb_pkg.sv
// rtl/psum_arb_pkg.sv - shared state encoding and helpers for psum buffer-port arbiters
package psum_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_buffer_arbiter_if.sv
// rtl/psum_buffer_arbiter_if.sv - requester and buffer write-port bundle of the psum arbiter
interface psum_buffer_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int IW = $clog2(N)
) ();

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            buf_ready;
  logic            buf_wen;
  logic [DW-1:0]   buf_wdata;
  logic [IW-1:0]   grant_id;
  logic            busy;

  // master: the PE write controllers plus the buffer; slave: the arbiter
  modport master (
    output req_valid, req_data, req_last, buf_ready,
    input  req_ready, buf_wen, buf_wdata, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, buf_ready,
    output req_ready, buf_wen, buf_wdata, grant_id, busy
  );

endinterface

// File: rtl/psum_buffer_arbiter_picker.sv
// rtl/psum_buffer_arbiter_picker.sv - rotated-priority first-set search, starting just after last
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  int j;

  // walk from the farthest candidate back to last+1 so the nearest set bit wins
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/psum_buffer_arbiter.sv
// rtl/psum_buffer_arbiter.sv - round-robin, burst-locked arbiter for the psum output buffer write port
module psum_buffer_arbiter
  import psum_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int IW = $clog2(N)
) (
  input logic                  clk,
  input logic                  rst,
  psum_buffer_arbiter_if.slave bus
);

  arb_state_t    state;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] last_grant;
  logic          busy_q;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          owner_valid;
  logic          owner_last;
  logic [DW-1:0] owner_data;
  logic          xfer;

  rr_priority_picker #(
    .N  (N),
    .IW (IW)
  ) u_picker (
    .req  (bus.req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    owner_valid = bus.req_valid[grant_q];
    owner_last  = bus.req_last[grant_q];
    owner_data  = bus.req_data[int'(grant_q)*DW +: DW];
    xfer        = (state == ARB_BURST) && owner_valid && bus.buf_ready;
  end

  // only the owner ever sees ready; everything is quiet while idle
  always_comb begin
    bus.req_ready = '0;
    bus.buf_wdata = '0;
    if (state == ARB_BURST) begin
      bus.req_ready[grant_q] = bus.buf_ready;
      bus.buf_wdata          = owner_data;
    end
  end

  assign bus.buf_wen  = xfer;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      grant_q    <= '0;
      last_grant <= IW'(N - 1);
      busy_q     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            busy_q  <= 1'b1;
            state   <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          // the grant is released only by an accepted last word
          if (xfer && owner_last) begin
            last_grant <= grant_q;
            busy_q     <= 1'b0;
            state      <= ARB_IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ARB_IDLE;
        end
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_wen_busy:     assert property (@(posedge clk) disable iff (rst) bus.buf_wen |-> busy_q);

endmodule

// File: tb/tb_psum_buffer_arbiter.sv
// tb/tb_psum_buffer_arbiter.sv - self-checking bench for psum_buffer_arbiter
module tb_psum_buffer_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0] mask;
    int           exp_g;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_buffer_arbiter_if #(.N(N), .DW(DW), .IW(IW)) bus ();

  psum_buffer_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          sb[$];
  logic          rst_req;
  logic [N-1:0]  en;
  logic [N-1:0]  gap;
  logic          bready;
  int            blen[N];
  int            pos[N];
  int            seq[N];
  int            plan[N];
  logic          s_busy;
  logic          s_wen;
  logic [IW-1:0] s_gid;
  logic [N-1:0]  s_rdy;
  logic [DW-1:0] s_wdata;
  int            pass_cnt;
  int            total_cnt;
  vec_t          tbl[12];

  function automatic logic [DW-1:0] word(input int i, input int s);
    return DW'((i << 12) | (s & 'hfff));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_words(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      sb.push_back('{id: IW'(i), data: word(i, plan[i])});
      plan[i]++;
    end
  endtask

  // one clock: drive at negedge, sample mid-low-phase, score writes, advance sources
  task automatic cycle();
    logic [N-1:0] acc;
    exp_t         e;
    @(negedge clk);
    rst = rst_req;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]           = en[i] & ~gap[i];
      bus.req_data[i*DW +: DW]   = word(i, seq[i]);
      bus.req_last[i]            = (pos[i] == blen[i] - 1);
    end
    bus.buf_ready = bready;
    #2;
    s_busy  = bus.busy;
    s_wen   = bus.buf_wen;
    s_gid   = bus.grant_id;
    s_rdy   = bus.req_ready;
    s_wdata = bus.buf_wdata;
    if (s_wen === 1'b1) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: got write 0x%0h from %0d, expected no write", s_wdata, s_gid);
      end else begin
        e = sb.pop_front();
        check("sb_data", 32'(s_wdata), 32'(e.data));
        check("sb_owner", 32'(s_gid), 32'(e.id));
      end
    end
    acc = bus.req_valid & bus.req_ready;
    for (int i = 0; i < N; i++) begin
      if (acc[i] === 1'b1) begin
        seq[i]++;
        pos[i] = (pos[i] == blen[i] - 1) ? 0 : pos[i] + 1;
      end
    end
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_req   = 1'b0;
    rst       = 1'b1;
    en        = '0;
    gap       = '0;
    bready    = 1'b1;
    for (int i = 0; i < N; i++) begin
      blen[i] = 1; pos[i] = 0; seq[i] = 0; plan[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.buf_ready = 1'b1;

    tbl[0]  = '{4'b1111, 0};
    tbl[1]  = '{4'b1111, 1};
    tbl[2]  = '{4'b1001, 3};
    tbl[3]  = '{4'b1001, 0};
    tbl[4]  = '{4'b0100, 2};
    tbl[5]  = '{4'b0010, 1};
    tbl[6]  = '{4'b1000, 3};
    tbl[7]  = '{4'b0011, 0};
    tbl[8]  = '{4'b0011, 1};
    tbl[9]  = '{4'b1101, 2};
    tbl[10] = '{4'b1101, 3};
    tbl[11] = '{4'b1101, 0};

    // reset state
    do_reset();
    cycle();
    check("rst_busy", 32'(s_busy), 0);
    check("rst_wen", 32'(s_wen), 0);
    check("rst_rdy", 32'(s_rdy), 0);
    check("rst_wdata", 32'(s_wdata), 0);

    // reset priority: all valid, 2-word bursts, grants 0 1 2 3 0 with 3-cycle period
    en = 4'b1111;
    for (int i = 0; i < N; i++) blen[i] = 2;
    for (int b = 0; b < 5; b++) push_words(b % N, 2);
    for (int c = 0; c < 15; c++) begin
      cycle();
      check("prio_busy", 32'(s_busy), 32'((c % 3) != 0));
      if ((c % 3) != 0) check("prio_grant", 32'(s_gid), 32'((c / 3) % N));
    end
    en = '0;
    cycle();
    check("prio_sb_empty", 32'(sb.size()), 0);

    // table of single-word bursts from reset priority
    do_reset();
    for (int i = 0; i < N; i++) blen[i] = 1;
    for (int r = 0; r < 12; r++) begin
      en = tbl[r].mask;
      push_words(tbl[r].exp_g, 1);
      cycle();
      check("tbl_idle_busy", 32'(s_busy), 0);
      check("tbl_idle_rdy", 32'(s_rdy), 0);
      cycle();
      check("tbl_grant", 32'(s_gid), 32'(tbl[r].exp_g));
      check("tbl_rdy", 32'(s_rdy), 32'(1 << tbl[r].exp_g));
      check("tbl_wen", 32'(s_wen), 1);
    end
    en = '0;

    // burst lock: requester 0 waits out requester 2's 4-word burst
    blen[2] = 4;
    en[2]   = 1'b1;
    push_words(2, 4);
    cycle();
    check("lock_idle", 32'(s_busy), 0);
    cycle();
    check("lock_gid", 32'(s_gid), 2);
    check("lock_w0", 32'(s_wen), 1);
    en[0]   = 1'b1;
    blen[0] = 1;
    push_words(0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("lock_rdy", 32'(s_rdy), 32'(4'b0100));
      check("lock_hold_gid", 32'(s_gid), 2);
    end
    en[2] = 1'b0;
    cycle();
    check("lock_bubble_busy", 32'(s_busy), 0);
    check("lock_bubble_rdy", 32'(s_rdy), 0);
    cycle();
    check("lock_next_busy", 32'(s_busy), 1);
    check("lock_next_gid", 32'(s_gid), 0);
    check("lock_next_rdy", 32'(s_rdy), 32'(4'b0001));
    en[0] = 1'b0;
    cycle();
    check("lock_sb_empty", 32'(sb.size()), 0);

    // backpressure: buffer full for 5 cycles mid-burst
    blen[1] = 4;
    en[1]   = 1'b1;
    push_words(1, 4);
    cycle();
    cycle();
    check("bp_w0", 32'(s_wen), 1);
    bready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_wen", 32'(s_wen), 0);
      check("bp_rdy", 32'(s_rdy), 0);
      check("bp_busy", 32'(s_busy), 1);
    end
    bready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_resume", 32'(s_wen), 1);
    end
    en[1] = 1'b0;
    cycle();
    check("bp_done_busy", 32'(s_busy), 0);
    check("bp_sb_empty", 32'(sb.size()), 0);

    // owner gap: owner 3 idles 3 cycles while requester 2 waits
    blen[3] = 3;
    en[3]   = 1'b1;
    push_words(3, 3);
    cycle();
    cycle();
    check("gap_gid", 32'(s_gid), 3);
    gap[3]  = 1'b1;
    en[2]   = 1'b1;
    blen[2] = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("gap_busy", 32'(s_busy), 1);
      check("gap_hold_gid", 32'(s_gid), 3);
      check("gap_wen", 32'(s_wen), 0);
      check("gap_rdy", 32'(s_rdy), 32'(4'b1000));
    end
    gap[3] = 1'b0;
    cycle();
    check("gap_w1", 32'(s_wen), 1);
    cycle();
    check("gap_w2", 32'(s_wen), 1);
    en[3] = 1'b0;
    push_words(2, 1);
    cycle();
    check("gap_bubble", 32'(s_busy), 0);
    cycle();
    check("gap_next_gid", 32'(s_gid), 2);
    check("gap_next_wen", 32'(s_wen), 1);
    en[2] = 1'b0;

    // wrap fairness: park last_grant at 3, then 1 and 3 alternate
    blen[3] = 1;
    en[3]   = 1'b1;
    push_words(3, 1);
    cycle();
    cycle();
    check("wrap_setup_gid", 32'(s_gid), 3);
    en[1]   = 1'b1;
    blen[1] = 1;
    push_words(1, 1);
    push_words(3, 1);
    push_words(1, 1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("wrap_bubble", 32'(s_busy), 0);
      cycle();
      check("wrap_gid", 32'(s_gid), (k == 1) ? 3 : 1);
    end
    en = '0;
    cycle();
    check("wrap_sb_empty", 32'(sb.size()), 0);

    // reset mid-burst, then a normal grant for requester 3
    blen[1] = 4;
    en[1]   = 1'b1;
    push_words(1, 3);
    cycle();
    cycle();
    cycle();
    rst_req = 1'b1;
    cycle();
    check("mid_rst_busy_before", 32'(s_busy), 1);
    rst_req = 1'b0;
    en[1]   = 1'b0;
    pos[1]  = 0;
    plan[1] = seq[1];
    cycle();
    check("mid_rst_busy", 32'(s_busy), 0);
    check("mid_rst_rdy", 32'(s_rdy), 0);
    check("mid_rst_wen", 32'(s_wen), 0);
    check("mid_rst_sb_empty", 32'(sb.size()), 0);
    blen[3] = 2;
    en[3]   = 1'b1;
    push_words(3, 2);
    cycle();
    cycle();
    check("post_rst_busy", 32'(s_busy), 1);
    check("post_rst_gid", 32'(s_gid), 3);
    cycle();
    check("post_rst_w1", 32'(s_wen), 1);
    en[3] = 1'b0;
    cycle();
    check("post_rst_idle", 32'(s_busy), 0);
    check("post_rst_sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
